// File: rtl/alu_mdu.sv
// alu_mdu: registered ALU with iterative multiply/divide and HI/LO registers.
// Define ALU_MDU_EARLY_EN to skip leading zero iterations in MUL/DIV.
module alu_mdu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       ALUCtrl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic             ZF,
    output logic             OF,
    output logic             DZ,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam logic [5:0] OP_ADDU  = 6'b000000;
    localparam logic [5:0] OP_SUBU  = 6'b000001;
    localparam logic [5:0] OP_ADD   = 6'b000100;
    localparam logic [5:0] OP_SUB   = 6'b000101;
    localparam logic [5:0] OP_AND   = 6'b001000;
    localparam logic [5:0] OP_OR    = 6'b001001;
    localparam logic [5:0] OP_NOT   = 6'b001010;
    localparam logic [5:0] OP_XOR   = 6'b001011;
    localparam logic [5:0] OP_EQ    = 6'b001100;
    localparam logic [5:0] OP_SLT   = 6'b001110;
    localparam logic [5:0] OP_SLTU  = 6'b001111;
    localparam logic [5:0] OP_MULT  = 6'b010000;
    localparam logic [5:0] OP_MULTU = 6'b010001;
    localparam logic [5:0] OP_DIV   = 6'b010010;
    localparam logic [5:0] OP_DIVU  = 6'b010011;
    localparam logic [5:0] OP_MFHI  = 6'b010100;
    localparam logic [5:0] OP_MFLO  = 6'b010101;
    localparam logic [5:0] OP_MTHI  = 6'b010110;
    localparam logic [5:0] OP_MTLO  = 6'b010111;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 2);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   opb;
    logic [WIDTH-1:0]     opm;
    logic                 neg_lo;
    logic                 neg_hi;
    logic                 is_mul;
    logic                 dz_r;

    logic [WIDTH:0]       sum_u;
    logic [WIDTH:0]       dif_u;
    logic [WIDTH-1:0]     alu_c;
    logic                 alu_of;
    logic                 signed_op;
    logic                 is_mul_op;
    logic                 sa;
    logic                 sb;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [CNT_W-1:0]     lz;
    logic                 mul_stop;
    logic [2*WIDTH-1:0]   cur_acc;
    logic [2*WIDTH-1:0]   cur_opb;
    logic [WIDTH-1:0]     cur_opm;
    logic [2*WIDTH-1:0]   mul_nxt;
    logic [WIDTH:0]       trial;
    logic [2*WIDTH-1:0]   div_nxt;
    logic [2*WIDTH-1:0]   prod_s;
    logic [WIDTH-1:0]     fin_hi;
    logic [WIDTH-1:0]     fin_lo;

    assign signed_op = (ALUCtrl == OP_MULT) || (ALUCtrl == OP_DIV);
    assign is_mul_op = (ALUCtrl == OP_MULT) || (ALUCtrl == OP_MULTU);
    assign sa        = signed_op & A[WIDTH-1];
    assign sb        = signed_op & B[WIDTH-1];
    assign mag_a     = sa ? -A : A;
    assign mag_b     = sb ? -B : B;

    // single-cycle result and overflow/carry for the plain ALU opcodes
    always_comb begin
        sum_u  = {1'b0, A} + {1'b0, B};
        dif_u  = {1'b0, A} - {1'b0, B};
        alu_c  = '0;
        alu_of = 1'b0;
        case (ALUCtrl)
            OP_ADD: begin
                alu_c  = sum_u[WIDTH-1:0];
                alu_of = (A[WIDTH-1] == B[WIDTH-1]) &&
                         (alu_c[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                alu_c  = dif_u[WIDTH-1:0];
                alu_of = (A[WIDTH-1] != B[WIDTH-1]) &&
                         (alu_c[WIDTH-1] != A[WIDTH-1]);
            end
            OP_ADDU: begin
                alu_c  = sum_u[WIDTH-1:0];
                alu_of = sum_u[WIDTH];
            end
            OP_SUBU: begin
                alu_c  = dif_u[WIDTH-1:0];
                alu_of = dif_u[WIDTH];
            end
            OP_SLT:  alu_c[0] = $signed(A) < $signed(B);
            OP_SLTU: alu_c[0] = A < B;
            OP_EQ:   alu_c[0] = A == B;
            OP_AND:  alu_c = A & B;
            OP_OR:   alu_c = A | B;
            OP_NOT:  alu_c = ~A;
            OP_XOR:  alu_c = A ^ B;
            OP_MFHI: alu_c = HI;
            OP_MFLO: alu_c = LO;
            OP_MTHI: alu_c = A;
            OP_MTLO: alu_c = A;
            default: alu_c = '0;
        endcase
    end

`ifdef ALU_MDU_EARLY_EN
    logic hit;
    // leading zeros of the dividend magnitude, used to pre-shift it
    always_comb begin
        lz  = '0;
        hit = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!hit) begin
                if (mag_a[i]) hit = 1'b1;
                else          lz  = lz + 1'b1;
            end
        end
    end
    assign mul_stop = (cur_opm[WIDTH-1:1] == '0);
`else
    assign lz       = '0;
    assign mul_stop = 1'b0;
`endif

    // the first iteration runs on the start edge from fresh operands
    always_comb begin
        if (state == S_IDLE) begin
            cur_opm = mag_b;
            cur_opb = {{WIDTH{1'b0}}, is_mul_op ? mag_a : mag_b};
            cur_acc = is_mul_op ? '0 : {{WIDTH{1'b0}}, mag_a << lz};
        end else begin
            cur_opm = opm;
            cur_opb = opb;
            cur_acc = acc;
        end
    end

    // one shift-add step, one restoring-divide step, and final sign fix-up
    always_comb begin
        mul_nxt = cur_opm[0] ? cur_acc + cur_opb : cur_acc;
        trial   = cur_acc[2*WIDTH-1:WIDTH-1] - {1'b0, cur_opb[WIDTH-1:0]};
        div_nxt = trial[WIDTH] ? {cur_acc[2*WIDTH-2:0], 1'b0}
                               : {trial[WIDTH-1:0], cur_acc[WIDTH-2:0], 1'b1};
        prod_s  = neg_lo ? -acc : acc;
        if (is_mul) begin
            fin_hi = prod_s[2*WIDTH-1:WIDTH];
            fin_lo = prod_s[WIDTH-1:0];
        end else begin
            fin_hi = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            fin_lo = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        end
    end

    // control FSM, iteration registers and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            acc    <= '0;
            opb    <= '0;
            opm    <= '0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            is_mul <= 1'b0;
            dz_r   <= 1'b0;
            C      <= '0;
            ZF     <= 1'b0;
            OF     <= 1'b0;
            DZ     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            HI     <= '0;
            LO     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    cnt <= '0;
                    case (ALUCtrl)
                        OP_MULT, OP_MULTU: begin
                            busy   <= 1'b1;
                            is_mul <= 1'b1;
                            dz_r   <= 1'b0;
                            neg_lo <= sa ^ sb;
                            neg_hi <= 1'b0;
                            acc    <= mul_nxt;
                            opb    <= cur_opb << 1;
                            opm    <= cur_opm >> 1;
                            state  <= mul_stop ? S_FIN : S_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            busy   <= 1'b1;
                            is_mul <= 1'b0;
                            opb    <= cur_opb;
                            opm    <= '0;
                            if (B == '0) begin
                                dz_r   <= 1'b1;
                                neg_lo <= 1'b0;
                                neg_hi <= 1'b0;
                                acc    <= {A, {WIDTH{1'b1}}};
                                state  <= S_FIN;
                            end else begin
                                dz_r   <= 1'b0;
                                neg_lo <= sa ^ sb;
                                neg_hi <= sa;
                                acc    <= div_nxt;
                                cnt    <= lz;
                                state  <= (lz >= CNT_W'(WIDTH - 1)) ? S_FIN : S_DIV;
                            end
                        end
                        default: begin
                            C    <= alu_c;
                            ZF   <= (alu_c == '0);
                            OF   <= alu_of;
                            DZ   <= 1'b0;
                            done <= 1'b1;
                            if (ALUCtrl == OP_MTHI) HI <= A;
                            if (ALUCtrl == OP_MTLO) LO <= A;
                        end
                    endcase
                end
                S_MUL: begin
                    acc <= mul_nxt;
                    opb <= opb << 1;
                    opm <= opm >> 1;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST || mul_stop) state <= S_FIN;
                end
                S_DIV: begin
                    acc <= div_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) state <= S_FIN;
                end
                S_FIN: begin
                    HI    <= fin_hi;
                    LO    <= fin_lo;
                    C     <= fin_lo;
                    ZF    <= (fin_lo == '0);
                    OF    <= 1'b0;
                    DZ    <= dz_r;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: scoreboard bench for alu_mdu, 32-bit configuration.
// Expected results come from a 64-bit arithmetic reference model.
module tb_alu_mdu;
    localparam logic [5:0] ADDU  = 6'b000000;
    localparam logic [5:0] SUBU  = 6'b000001;
    localparam logic [5:0] ADD   = 6'b000100;
    localparam logic [5:0] SUB   = 6'b000101;
    localparam logic [5:0] AND_  = 6'b001000;
    localparam logic [5:0] OR_   = 6'b001001;
    localparam logic [5:0] NOT_  = 6'b001010;
    localparam logic [5:0] XOR_  = 6'b001011;
    localparam logic [5:0] EQ    = 6'b001100;
    localparam logic [5:0] SLT   = 6'b001110;
    localparam logic [5:0] SLTU  = 6'b001111;
    localparam logic [5:0] MULT  = 6'b010000;
    localparam logic [5:0] MULTU = 6'b010001;
    localparam logic [5:0] DIV   = 6'b010010;
    localparam logic [5:0] DIVU  = 6'b010011;
    localparam logic [5:0] MFHI  = 6'b010100;
    localparam logic [5:0] MFLO  = 6'b010101;
    localparam logic [5:0] MTHI  = 6'b010110;
    localparam logic [5:0] MTLO  = 6'b010111;
    localparam logic [5:0] NUL   = 6'b111111;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;
`ifdef ALU_MDU_EARLY_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] c;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        of;
        logic        zf;
        logic        dz;
        logic [7:0]  lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  ctrl = 6'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic [31:0] c;
    logic        zf;
    logic        of;
    logic        dz;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    always #5 clk = ~clk;

    alu_mdu #(.WIDTH(32), .CNT_W(6)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .ALUCtrl(ctrl),
        .A      (a),
        .B      (b),
        .C      (c),
        .ZF     (zf),
        .OF     (of),
        .DZ     (dz),
        .busy   (busy),
        .done   (done),
        .HI     (hi),
        .LO     (lo)
    );

    task automatic push_exp(input logic [5:0] op, input logic [31:0] x,
                            input logic [31:0] y);
        exp_t e;
        longint sx, sy, p, r;
        longint unsigned ux, uy, up, ur;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        e = '0;
        e.hi = m_hi;
        e.lo = m_lo;
        e.lat = 8'd1;
        case (op)
            ADD: begin
                p = sx + sy;
                e.c = p[31:0];
                e.of = (p > SMAX) || (p < SMIN);
            end
            SUB: begin
                p = sx - sy;
                e.c = p[31:0];
                e.of = (p > SMAX) || (p < SMIN);
            end
            ADDU: begin
                up = ux + uy;
                e.c = up[31:0];
                e.of = up > 64'h0000_0000_FFFF_FFFF;
            end
            SUBU: begin
                e.c = x - y;
                e.of = ux < uy;
            end
            SLT:   e.c = (sx < sy) ? 32'd1 : 32'd0;
            SLTU:  e.c = (ux < uy) ? 32'd1 : 32'd0;
            EQ:    e.c = (x == y) ? 32'd1 : 32'd0;
            AND_:  e.c = x & y;
            OR_:   e.c = x | y;
            NOT_:  e.c = ~x;
            XOR_:  e.c = x ^ y;
            MFHI:  e.c = m_hi;
            MFLO:  e.c = m_lo;
            MTHI: begin e.c = x; e.hi = x; end
            MTLO: begin e.c = x; e.lo = x; end
            MULT: begin
                p = sx * sy;
                e.hi = p[63:32];
                e.lo = p[31:0];
                e.lat = 8'd33;
            end
            MULTU: begin
                up = ux * uy;
                e.hi = up[63:32];
                e.lo = up[31:0];
                e.lat = 8'd33;
            end
            DIV: begin
                if (y == 32'd0) begin
                    e.hi = x; e.lo = 32'hFFFF_FFFF; e.dz = 1'b1; e.lat = 8'd2;
                end else begin
                    p = sx / sy;
                    r = sx % sy;
                    e.hi = r[31:0];
                    e.lo = p[31:0];
                    e.lat = 8'd33;
                end
            end
            DIVU: begin
                if (y == 32'd0) begin
                    e.hi = x; e.lo = 32'hFFFF_FFFF; e.dz = 1'b1; e.lat = 8'd2;
                end else begin
                    up = ux / uy;
                    ur = ux % uy;
                    e.hi = ur[31:0];
                    e.lo = up[31:0];
                    e.lat = 8'd33;
                end
            end
            default: e.c = 32'd0;
        endcase
        if (op == MULT || op == MULTU || op == DIV || op == DIVU) e.c = e.lo;
        m_hi = e.hi;
        m_lo = e.lo;
        e.zf = (e.c == 32'd0);
        exp_q.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge where done is seen.
    task automatic run(input logic [5:0] op, input logic [31:0] x,
                       input logic [31:0] y, output int lat, output int bz);
        push_exp(op, x, y);
        ctrl = op; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        bz = 0;
        while (done !== 1'b1 && lat < 200) begin
            if (busy === 1'b1) bz++;
            a = $urandom;
            b = $urandom;
            ctrl = AND_;
            @(negedge clk);
            lat++;
        end
        if (done !== 1'b1) lat = -1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests++;
        if ({c, hi, lo} !== 96'd0) begin
            fails++;
            $display("FAIL reset_data C=%h HI=%h LO=%h want all 0", c, hi, lo);
        end
        tests++;
        if ({zf, of, dz, busy, done} !== 5'd0) begin
            fails++;
            $display("FAIL reset_flags zf,of,dz,busy,done=%b want 00000",
                     {zf, of, dz, busy, done});
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if ({busy, done, c} !== 34'd0) begin
            fails++;
            $display("FAIL post_reset busy=%b done=%b C=%h want 0", busy, done, c);
        end
    endtask

    task automatic test_alu();
        logic [5:0]  ops [15] = '{ADD, SUBU, SUB, ADDU, ADD, SLT, SLTU, EQ,
                                  AND_, OR_, NOT_, XOR_, NUL, 6'b100000, SUBU};
        logic [31:0] xa [15] = '{32'h7FFF_FFFF, 32'd0, 32'h8000_0000,
                                 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                                 32'hFFFF_FFFD, 32'h55, 32'hF0F0, 32'hF0F0,
                                 32'h0F0F_0F0F, 32'hAAAA_5555, 32'h1234,
                                 32'h1234, 32'd5};
        logic [31:0] xb [15] = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd2,
                                 32'd2, 32'h55, 32'hFF00, 32'hFF00, 32'd9,
                                 32'hFFFF_0000, 32'h5678, 32'h5678, 32'd3};
        exp_t e;
        int lat, bz;
        for (int i = 0; i < 15; i++) begin
            run(ops[i], xa[i], xb[i], lat, bz);
            e = exp_q.pop_front();
            tests++;
            if (lat != 1) begin
                fails++;
                $display("FAIL alu%0d_latency got %0d want 1", i, lat);
            end
            tests++;
            if (c !== e.c || of !== e.of || zf !== e.zf || dz !== e.dz) begin
                fails++;
                $display("FAIL alu%0d op=%b C=%h OF=%b ZF=%b DZ=%b want %h %b %b %b",
                         i, ops[i], c, of, zf, dz, e.c, e.of, e.zf, e.dz);
            end
        end
    endtask

    task automatic test_muldiv();
        logic [5:0]  ops [12] = '{MULT, MFHI, MULTU, DIV, DIVU, MFLO, DIV,
                                  DIVU, MULT, DIV, MULT, DIV};
        logic [31:0] xa [12] = '{32'hFFFF_FFFD, 32'd0, 32'hFFFF_FFFF,
                                 32'hFFFF_FFF9, 32'd100, 32'd0,
                                 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000,
                                 32'd0, 32'd0, 32'd7};
        logic [31:0] xb [12] = '{32'd7, 32'd0, 32'hFFFF_FFFF, 32'd2, 32'd0,
                                 32'd0, 32'hFFFF_FFFF, 32'd10, 32'h8000_0000,
                                 32'd5, 32'd5, 32'hFFFF_FFFE};
        exp_t e;
        int lat, bz;
        bit lat_ok;
        for (int i = 0; i < 12; i++) begin
            run(ops[i], xa[i], xb[i], lat, bz);
            e = exp_q.pop_front();
            if (EARLY && e.lat > 8'd2)
                lat_ok = (lat >= 2) && (lat <= int'(e.lat));
            else
                lat_ok = (lat == int'(e.lat));
            tests++;
            if (!lat_ok || bz != lat - 1) begin
                fails++;
                $display("FAIL md%0d_timing latency=%0d busy_cycles=%0d want %0d/%0d",
                         i, lat, bz, e.lat, e.lat - 1);
            end
            tests++;
            if (c !== e.c || hi !== e.hi || lo !== e.lo) begin
                fails++;
                $display("FAIL md%0d_data op=%b C=%h HI=%h LO=%h want %h %h %h",
                         i, ops[i], c, hi, lo, e.c, e.hi, e.lo);
            end
            tests++;
            if (of !== e.of || zf !== e.zf || dz !== e.dz) begin
                fails++;
                $display("FAIL md%0d_flags OF=%b ZF=%b DZ=%b want %b %b %b",
                         i, of, zf, dz, e.of, e.zf, e.dz);
            end
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || c !== e.c) begin
            fails++;
            $display("FAIL done_pulse done=%b C=%h want 0 %h", done, c, e.c);
        end
    endtask

    task automatic test_busy_ignore();
        exp_t e;
        int lat;
        push_exp(MULTU, 32'h1234_5678, 32'h0000_9ABC);
        ctrl = MULTU; a = 32'h1234_5678; b = 32'h0000_9ABC; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 200) begin
            if (lat == 4) begin
                start = 1'b1; ctrl = AND_; a = 32'hFFFF; b = 32'hFF;
            end else begin
                start = 1'b0; a = $urandom; b = $urandom;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        e = exp_q.pop_front();
        tests++;
        if (EARLY ? (lat < 2 || lat > 33) : (lat != 33)) begin
            fails++;
            $display("FAIL ignore_latency got %0d want %0d", lat, e.lat);
        end
        tests++;
        if (c !== e.c || hi !== e.hi || lo !== e.lo) begin
            fails++;
            $display("FAIL ignore_data C=%h HI=%h LO=%h want %h %h %h",
                     c, hi, lo, e.c, e.hi, e.lo);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL ignore_no_replay done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0]  ops [7] = '{MTLO, MULTU, ADD, MFLO, DIV, MFHI, MTHI};
        logic [31:0] xa [7] = '{32'h1234, 32'd6, 32'd1, 32'd0, 32'd7, 32'd0,
                                32'hCAFE_0000};
        logic [31:0] xb [7] = '{32'd0, 32'd7, 32'd2, 32'd0, 32'hFFFF_FFFE,
                                32'd0, 32'd0};
        exp_t e;
        int lat, bz;
        for (int i = 0; i < 7; i++) begin
            run(ops[i], xa[i], xb[i], lat, bz);
            e = exp_q.pop_front();
            tests++;
            if (lat < 1 || c !== e.c || hi !== e.hi || lo !== e.lo) begin
                fails++;
                $display("FAIL b2b%0d lat=%0d C=%h HI=%h LO=%h want %h %h %h",
                         i, lat, c, hi, lo, e.c, e.hi, e.lo);
            end
        end
    endtask

    task automatic test_early();
        exp_t e;
        int lat, bz;
        run(MULTU, 32'd5, 32'd3, lat, bz);
        e = exp_q.pop_front();
        tests++;
        if (EARLY ? (lat < 2 || lat > 4) : (lat != 33)) begin
            fails++;
            $display("FAIL early_latency got %0d want %s", lat,
                     EARLY ? "2..4" : "33");
        end
        tests++;
        if (lo !== e.lo || c !== 32'd15) begin
            fails++;
            $display("FAIL early_data LO=%h C=%h want %h 0000000f", lo, c, e.lo);
        end
    endtask

    task automatic test_reset_abort();
        exp_t e;
        int lat, bz, pulses;
        ctrl = DIVU; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL abort_busy_before got %b want 1", busy);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || {c, hi, lo} !== 96'd0) begin
            fails++;
            $display("FAIL abort_clear busy=%b done=%b C=%h HI=%h LO=%h want 0",
                     busy, done, c, hi, lo);
        end
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        tests++;
        if (pulses != 0) begin
            fails++;
            $display("FAIL abort_no_done got %0d done/busy cycles want 0", pulses);
        end
        run(SLT, 32'hFFFF_FFFD, 32'd2, lat, bz);
        e = exp_q.pop_front();
        tests++;
        if (lat != 1 || c !== e.c || hi !== 32'd0 || lo !== 32'd0) begin
            fails++;
            $display("FAIL abort_slt lat=%0d C=%h HI=%h LO=%h want 1 %h 0 0",
                     lat, c, hi, lo, e.c);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_muldiv();
        test_busy_ignore();
        test_back_to_back();
        test_early();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised successor to the datapath ALU for the multi-cycle CPU.
- Registers every result and adds an iterative multiply/divide unit with HI/LO registers behind a start/busy/done handshake.
- The control FSM pulses start in EXE and waits for done before advancing.
- Keeps the existing 6-bit ALUCtrl encodings and adds the multiply/divide and HI/LO opcodes listed below.

Parameters:
- WIDTH, 32: operand, result and HI/LO width; must be at least 4.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous reset, active low
- start  input  1  one-cycle request; sampled only when busy=0
- ALUCtrl  input  6  operation code
- A  input  WIDTH  operand A (rs)
- B  input  WIDTH  operand B (rt or immediate)
- C  output  WIDTH  registered result
- ZF  output  1  registered, C==0
- OF  output  1  registered overflow/carry flag
- DZ  output  1  registered, divide by zero on last DIV/DIVU
- busy  output  1  multi-cycle operation in progress
- done  output  1  one-cycle pulse when C/ZF/OF/DZ are updated
- HI  output  WIDTH  HI register
- LO  output  WIDTH  LO register

Behaviour:
- Opcode encodings:
  - Existing: 000100 ADD, 000101 SUB, 000000 ADDU, 000001 SUBU, 001110 SLT, 001100 EQ, 001000 AND, 001001 OR, 001010 NOT(~A), 001011 XOR, 111111 NULL (C=0).
  - New: 001111 SLTU, 010000 MULT, 010001 MULTU, 010010 DIV, 010011 DIVU, 010100 MFHI, 010101 MFLO, 010110 MTHI, 010111 MTLO.
  - Any other code behaves as NULL.
- Reset (rst_n low, async): state IDLE; C=0, ZF=0, OF=0, DZ=0, busy=0, done=0, HI=0, LO=0, counter=0.
- FSM states: IDLE, MUL, DIV, FIN.
- IDLE with start=1:
  - Single-cycle ops: C/ZF/OF load on the next edge, done=1 that cycle, state stays IDLE. Latency is 1 cycle.
  - MT ops: MTHI sets HI=A; MTLO sets LO=A; C=A.
  - MF ops: C=HI or C=LO at the start edge.
  - MULT/MULTU: go to MUL. DIV/DIVU: go to DIV, or to FIN directly on divide by zero. Either way busy=1 and the counter is cleared.
- MUL: shift-add on operand magnitudes, one bit per cycle, WIDTH cycles. Then FIN.
- DIV: restoring division on magnitudes, one quotient bit per cycle, WIDTH cycles. Then FIN.
- FIN:
  - Apply signs. MULT product is negated when sign(A)^sign(B). DIV quotient sign is sign(A)^sign(B); remainder sign is sign(A).
  - Write HI (high product / remainder) and LO (low product / quotient). C=LO.
  - done=1, busy=0, return to IDLE.
  - Multiply/divide latency from start to done is WIDTH+1 cycles.
- Flags:
  - ADD/SUB: OF = signed overflow.
  - ADDU/SUBU: OF = carry-out / borrow.
  - All other ops clear OF.
  - ZF = (C==0), updated only with done.
  - DZ is set only by DIV/DIVU with B==0 and cleared by every other completed op.
- Divide by zero: no iterations. HI=A, LO=all ones, C=all ones, done on the second cycle after start.
- DIV with A=MIN and B=-1: LO=MIN, HI=0, OF=0.
- start while busy=1 is ignored; no queueing.
- C/ZF/OF hold their values between done pulses.
- HI/LO change only on MTHI/MTLO or FIN.
- A and B are latched at start and may change while busy.
- Reset mid-operation aborts: all state is cleared and no done is issued.

Optional Feature:
- Macro: ALU_MDU_EARLY_EN.
- Defined:
  - MULTU/MULT skip leading iterations while the remaining multiplier magnitude is zero.
  - DIVU/DIV skip leading iterations while the dividend's leading bits are zero.
  - Latency is at least 2 cycles (start to done) and at most WIDTH+1.
  - Results are identical to the undefined case.
- Undefined: fixed WIDTH+1 latency for all non-zero-divisor MUL/DIV ops.

Test Plan:
- ADD with A=0x7FFFFFFF, B=1, start pulse -> one cycle later done=1, C=0x80000000, OF=1, ZF=0. SUBU 0-1 -> C=0xFFFFFFFF, OF=1.
- MULT with A=-3, B=7 -> busy for 32 cycles, done at cycle 33, HI=0xFFFFFFFF, LO=0xFFFFFFEB, C=LO. Then MFHI -> C=0xFFFFFFFF after 1 cycle.
- DIV with A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/0 -> DZ=1, LO=0xFFFFFFFF, HI=100, done on the 2nd cycle.
- MULTU started, then start with AND issued at cycle 5 -> AND ignored, MULTU result correct. A and B changed while busy -> no effect.
- rst_n pulled low at cycle 10 of a DIVU -> immediately busy=0, HI=LO=C=0, no done. A new SLT -3<2 after release -> C=1.
- With ALU_MDU_EARLY_EN: MULTU 5*3 -> done in no more than 4 cycles with LO=15. Without it -> 33 cycles.
